// File: rtl/clock_meter.sv
// Measures period and high time of a slow clock in core cycles and flags a stopped clock.
// Results land one cycle after the closing rise is detected; sig_in sees SYNC_STAGES cycles of sync delay.
module clock_meter #(
  parameter int CNT_W       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level
);

  typedef enum logic [2:0] {IDLE, ARM_LOW, ARM_RISE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_prev, rise, fall, timeout, trip;
  logic [CNT_W-1:0]       cnt, cnt_nxt, hi_tmp, hi_tmp_nxt;
  logic [CNT_W-1:0]       period_nxt, high_time_nxt;
  logic                   valid_nxt, stuck_nxt, stuck_level_nxt;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_prev;
  assign fall    = ~s & s_prev;
  assign timeout = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_prev <= s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      hi_tmp      <= '0;
      period      <= '0;
      high_time   <= '0;
      valid       <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      hi_tmp      <= hi_tmp_nxt;
      period      <= period_nxt;
      high_time   <= high_time_nxt;
      valid       <= valid_nxt;
      stuck       <= stuck_nxt;
      stuck_level <= stuck_level_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = timeout ? cnt : cnt + 1'b1;
    hi_tmp_nxt      = hi_tmp;
    period_nxt      = period;
    high_time_nxt   = high_time;
    valid_nxt       = 1'b0;
    stuck_nxt       = stuck;
    stuck_level_nxt = stuck_level;
    trip            = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (enable) state_nxt = ARM_LOW;
      end
      // A high level here may be a partial period, so wait for low first.
      ARM_LOW: begin
        if (!s) state_nxt = ARM_RISE;
        else    trip = timeout;
      end
      ARM_RISE: begin
        if (rise) begin
          state_nxt = HIGH;
          cnt_nxt   = CNT_ONE;
        end else begin
          trip = timeout;
        end
      end
      HIGH: begin
        if (fall) begin
          state_nxt  = LOW;
          hi_tmp_nxt = cnt;
        end else begin
          trip = timeout;
        end
      end
      LOW: begin
        if (rise) begin
          state_nxt     = HIGH;
          cnt_nxt       = CNT_ONE;
          period_nxt    = cnt;
          high_time_nxt = hi_tmp;
          valid_nxt     = 1'b1;
          stuck_nxt     = 1'b0;
        end else begin
          trip = timeout;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (trip) begin
      state_nxt       = ARM_LOW;
      cnt_nxt         = '0;
      stuck_nxt       = 1'b1;
      stuck_level_nxt = s;
    end

    // Disable overrides everything, including a rise that would close a period.
    if (!enable) begin
      state_nxt       = IDLE;
      cnt_nxt         = '0;
      hi_tmp_nxt      = hi_tmp;
      period_nxt      = period;
      high_time_nxt   = high_time;
      valid_nxt       = 1'b0;
      stuck_nxt       = 1'b0;
      stuck_level_nxt = stuck_level;
    end
  end

endmodule

// File: tb/tb_clock_meter.sv
// Scoreboard bench for clock_meter: the stimulus generator counts its own waveform and queues expected results.
module tb_clock_meter;

  localparam int CNT_W = 12;

  typedef struct {
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] hi;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n, sig_in, enable;
  logic [CNT_W-1:0] period, high_time;
  logic             valid, stuck, stuck_level;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0, miscompares = 0;
  int   cyc = 0, since_rise = 0, hi_cnt = 0;
  int   last_vcyc = 0, prev_vcyc = 0, nvalid = 0;
  bit   cur_level = 1'b0, armed = 1'b0, have_prev = 1'b0;

  clock_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
    .period(period), .high_time(high_time), .valid(valid),
    .stuck(stuck), .stuck_level(stuck_level)
  );

  always #5 clk = ~clk;

  // Cycle counts of the applied waveform, taken at the sampling edge.
  always @(posedge clk) begin
    cyc++;
    since_rise++;
    if (sig_in) hi_cnt++;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid === 1'b1) begin
      nvalid++;
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: valid=1 period=%0d high_time=%0d, required no pulse", period, high_time);
      end else begin
        mon_e = exp_q.pop_front();
        if (period !== mon_e.per || high_time !== mon_e.hi) begin
          miscompares++;
          $display("FAIL measurement: got %0d/%0d, required %0d/%0d", period, high_time, mon_e.per, mon_e.hi);
        end
        vectors++;
        if (stuck !== 1'b0) begin
          miscompares++;
          $display("FAIL stuck_at_valid: got %0b, required 0", stuck);
        end
      end
    end
  end

  task automatic drive(input logic level, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (level && !cur_level) begin
        if (armed && have_prev) begin
          e.per = 12'(since_rise);
          e.hi  = 12'(hi_cnt);
          exp_q.push_back(e);
        end
        have_prev  = armed;
        since_rise = 0;
        hi_cnt     = 0;
      end
      cur_level = level;
      sig_in    = level;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clk_run(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    vectors += 5;
    if (period !== '0)      begin miscompares++; $display("FAIL reset_period: got %0d, required 0", period); end
    if (high_time !== '0)   begin miscompares++; $display("FAIL reset_high_time: got %0d, required 0", high_time); end
    if (valid !== 1'b0)     begin miscompares++; $display("FAIL reset_valid: got %0b, required 0", valid); end
    if (stuck !== 1'b0)     begin miscompares++; $display("FAIL reset_stuck: got %0b, required 0", stuck); end
    if (stuck_level !== 1'b0) begin miscompares++; $display("FAIL reset_stuck_level: got %0b, required 0", stuck_level); end
    #20 rst_n = 1'b1;
  endtask

  task automatic test_symmetric();
    int n0;
    enable = 1'b1; armed = 1'b1; have_prev = 1'b0;
    drive(1'b0, 6);
    n0 = nvalid;
    clk_run(3, 3, 6);
    settle();
    vectors += 3;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL sym_pending: got %0d outstanding, required 0", exp_q.size()); end
    if (nvalid - n0 != 5) begin miscompares++; $display("FAIL sym_count: got %0d valids, required 5", nvalid - n0); end
    if (last_vcyc - prev_vcyc != 6) begin miscompares++; $display("FAIL sym_interval: got %0d, required 6", last_vcyc - prev_vcyc); end
  endtask

  task automatic test_asymmetric();
    clk_run(1, 4, 5);
    clk_run(7, 2, 3);
    clk_run(1, 1, 4);
    settle();
    vectors += 2;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL asym_pending: got %0d outstanding, required 0", exp_q.size()); end
    if (period !== 12'd2 || high_time !== 12'd1) begin
      miscompares++; $display("FAIL asym_min: got %0d/%0d, required 2/1", period, high_time);
    end
  endtask

  task automatic test_stuck();
    clk_run(3, 3, 3);
    drive(1'b1, 1);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (stuck === 1'b1) break;
    end
    vectors += 5;
    if (stuck !== 1'b1) begin miscompares++; $display("FAIL stuck_set: got %0b, required 1", stuck); end
    if (cyc - last_vcyc != 4095) begin miscompares++; $display("FAIL stuck_delay: got %0d cycles, required 4095", cyc - last_vcyc); end
    if (stuck_level !== 1'b1) begin miscompares++; $display("FAIL stuck_level: got %0b, required 1", stuck_level); end
    if (period !== 12'd6 || high_time !== 12'd3) begin
      miscompares++; $display("FAIL stuck_hold: got %0d/%0d, required 6/3", period, high_time);
    end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL stuck_pending: got %0d outstanding, required 0", exp_q.size()); end
    armed = 1'b1; have_prev = 1'b0;
    drive(1'b0, 3);
    vectors++;
    if (stuck !== 1'b1) begin miscompares++; $display("FAIL stuck_persist: got %0b, required 1", stuck); end
    clk_run(3, 3, 3);
    settle();
    vectors += 2;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL resume_pending: got %0d outstanding, required 0", exp_q.size()); end
    if (stuck !== 1'b0) begin miscompares++; $display("FAIL resume_stuck: got %0b, required 0", stuck); end
  endtask

  task automatic test_enable_drop();
    clk_run(3, 3, 2);
    drive(1'b1, 3);
    enable = 1'b0; armed = 1'b0; have_prev = 1'b0;
    drive(1'b0, 3);
    clk_run(3, 3, 2);
    settle();
    vectors += 3;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL drop_pending: got %0d outstanding, required 0", exp_q.size()); end
    if (period !== 12'd6 || high_time !== 12'd3) begin
      miscompares++; $display("FAIL drop_hold: got %0d/%0d, required 6/3", period, high_time);
    end
    if (stuck !== 1'b0) begin miscompares++; $display("FAIL drop_stuck: got %0b, required 0", stuck); end
    enable = 1'b1; armed = 1'b1; have_prev = 1'b0;
    drive(1'b0, 4);
    clk_run(2, 5, 3);
    settle();
    vectors += 2;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL reenable_pending: got %0d outstanding, required 0", exp_q.size()); end
    if (period !== 12'd7 || high_time !== 12'd2) begin
      miscompares++; $display("FAIL reenable_meas: got %0d/%0d, required 7/2", period, high_time);
    end
  endtask

  task automatic test_enable_vs_rise();
    clk_run(4, 4, 2);
    drive(1'b1, 2);
    drive(1'b0, 3);
    armed = 1'b0; have_prev = 1'b0;
    drive(1'b1, 1);
    drive(1'b1, 1);
    enable = 1'b0;
    drive(1'b1, 2);
    drive(1'b0, 3);
    settle();
    vectors += 2;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL evr_pending: got %0d outstanding, required 0", exp_q.size()); end
    if (period !== 12'd8 || high_time !== 12'd4) begin
      miscompares++; $display("FAIL evr_hold: got %0d/%0d, required 8/4", period, high_time);
    end
  endtask

  task automatic test_reset_midrun();
    enable = 1'b1; armed = 1'b1; have_prev = 1'b0;
    drive(1'b0, 4);
    clk_run(3, 3, 2);
    drive(1'b1, 1);
    drive(1'b1, 1);
    #3 rst_n = 1'b0;
    #1;
    vectors += 5;
    if (period !== '0)      begin miscompares++; $display("FAIL midrst_period: got %0d, required 0", period); end
    if (high_time !== '0)   begin miscompares++; $display("FAIL midrst_high_time: got %0d, required 0", high_time); end
    if (valid !== 1'b0)     begin miscompares++; $display("FAIL midrst_valid: got %0b, required 0", valid); end
    if (stuck !== 1'b0)     begin miscompares++; $display("FAIL midrst_stuck: got %0b, required 0", stuck); end
    if (stuck_level !== 1'b0) begin miscompares++; $display("FAIL midrst_stuck_level: got %0b, required 0", stuck_level); end
    exp_q.delete();
    armed = 1'b0; have_prev = 1'b0;
    drive(1'b0, 3);
    rst_n = 1'b1;
    armed = 1'b1;
    drive(1'b0, 4);
    clk_run(2, 2, 4);
    settle();
    vectors += 2;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL midrst_pending: got %0d outstanding, required 0", exp_q.size()); end
    if (period !== 12'd4 || high_time !== 12'd2) begin
      miscompares++; $display("FAIL midrst_meas: got %0d/%0d, required 4/2", period, high_time);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    enable = 1'b0;
    #1;
    test_reset();
    test_symmetric();
    test_asymmetric();
    test_stuck();
    test_enable_drop();
    test_enable_vs_rise();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
